// File: rtl/hello_world_tx.sv
// hello_world_tx: sends the fixed text "hello world!\n" as 8N1 UART frames
// on tx, one message per accepted start request (or once after reset when
// AUTO_START is set). byte_strobe/byte_out expose the character being framed.
module hello_world_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter bit AUTO_START   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       byte_strobe,
    output logic [7:0] byte_out
);

    // Baud counter wide enough for CLKS_PER_BIT-1; guarded so a bad
    // parameter reaches the elaboration check below instead of a zero width.
    localparam int CW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd12;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("hello_world_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    idx;
    logic [3:0]    idx_n;
    logic [7:0]    byte_q;
    logic          done_q;
    logic          auto_pend;
    logic          bit_end;
    logic          go;

    function automatic logic [7:0] rom_byte(input logic [3:0] i);
        logic [7:0] c;
        case (i)
            4'd0:    c = 8'h68; // h
            4'd1:    c = 8'h65; // e
            4'd2:    c = 8'h6C; // l
            4'd3:    c = 8'h6C; // l
            4'd4:    c = 8'h6F; // o
            4'd5:    c = 8'h20; // space
            4'd6:    c = 8'h77; // w
            4'd7:    c = 8'h6F; // o
            4'd8:    c = 8'h72; // r
            4'd9:    c = 8'h6C; // l
            4'd10:   c = 8'h64; // d
            4'd11:   c = 8'h21; // !
            4'd12:   c = 8'h0A; // newline
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign bit_end = (baud_cnt == BAUD_LAST);
    // The done cycle is already IDLE, so start is masked there: a request
    // is only accepted from the cycle after done onwards.
    assign go      = (start | auto_pend) & ~done_q;

    // State register and message index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state and next-index selection
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (go) begin
                    state_n = START;
                    idx_n   = '0;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (idx == LAST_IDX) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        state_n = START;
                        idx_n   = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Baud/bit counters, framed byte, done pulse and auto-start one-shot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_q    <= '0;
            done_q    <= 1'b0;
            auto_pend <= AUTO_START;
        end else begin
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + CW'(1);

            if (state != DATA)  bit_cnt <= '0;
            else if (bit_end)   bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;

            if (state_n == START && state != START) byte_q <= rom_byte(idx_n);

            done_q    <= (state == STOP) && bit_end && (idx == LAST_IDX);
            auto_pend <= 1'b0;
        end
    end

    // Line level and status outputs decoded from state
    always_comb begin
        tx          = 1'b1;
        busy        = (state != IDLE);
        byte_strobe = (state == START) && (baud_cnt == '0);
        case (state)
            IDLE:    tx = 1'b1;
            START:   tx = 1'b0;
            DATA:    tx = byte_q[bit_cnt];
            STOP:    tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

    assign done     = done_q;
    assign byte_out = byte_q;

endmodule

// File: tb/tb_hello_world_tx.sv
// Directed bench for hello_world_tx: a default instance driven by start and
// an AUTO_START instance; tx is decoded with a mid-bit sampling UART model.
module tb_hello_world_tx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rst_a = 1'b0;
    logic       start_a = 1'b0;
    logic       tx, busy, done, byte_strobe;
    logic [7:0] byte_out;
    logic       tx_a, busy_a, done_a, byte_strobe_a;
    logic [7:0] byte_out_a;

    int vectors     = 0;
    int miscompares = 0;

    int cyc       = 0;
    int strobes   = 0;
    int dones     = 0;
    int dones_a   = 0;
    int busy_hi   = 0;
    int busy_rise = 0;
    int done_at   = 0;
    logic busy_prev = 1'b0;
    logic [7:0] blog [256];

    logic [7:0] msg [13] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    always #5 clk = ~clk;

    hello_world_tx #(.CLKS_PER_BIT(8), .AUTO_START(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx(tx), .busy(busy),
        .done(done), .byte_strobe(byte_strobe), .byte_out(byte_out)
    );

    hello_world_tx #(.CLKS_PER_BIT(8), .AUTO_START(1'b1)) dut_auto (
        .clk(clk), .rst_n(rst_a), .start(start_a), .tx(tx_a), .busy(busy_a),
        .done(done_a), .byte_strobe(byte_strobe_a), .byte_out(byte_out_a)
    );

    // Cycle counter
    always @(posedge clk) cyc++;

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (byte_strobe) begin
            blog[strobes[7:0]] = byte_out;
            strobes++;
        end
        if (busy && !busy_prev) busy_rise = cyc;
        if (busy) busy_hi++;
        busy_prev = busy;
        if (done) begin
            dones++;
            done_at = cyc;
        end
        if (done_a) dones_a++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic txsel(input bit sel);
        return sel ? tx_a : tx;
    endfunction

    // UART receiver: find the start bit, sample every bit at its centre
    task automatic rx_frame(input bit sel, output logic [7:0] d);
        int n;
        n = 0;
        d = '0;
        while (txsel(sel) !== 1'b0 && n < 200) begin
            tick;
            n++;
        end
        chk("rx_start_found", 32'(n < 200), 32'd1);
        repeat (4) tick;
        chk("rx_start_bit", 32'(txsel(sel)), 32'd0);
        for (int b = 0; b < 8; b++) begin
            repeat (8) tick;
            d[b] = txsel(sel);
        end
        repeat (8) tick;
        chk("rx_stop_bit", 32'(txsel(sel)), 32'd1);
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while (!(sel ? done_a : done) && n < 2000) begin
            tick;
            n++;
        end
        chk("done_seen", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] h;
        logic       e;
        int         b;
        int         n;
        int         s0, d0, bh0;

        // Reset held with start toggling: line idle, nothing active
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick;
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_strobe", 32'(byte_strobe), 32'd0);
            chk("rst_byte_out", 32'(byte_out), 32'h00);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_strobe", 32'(byte_strobe), 32'd0);
        end

        // Message 1: first-frame bit levels, then timing and byte log
        s0 = strobes; d0 = dones; bh0 = busy_hi;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("m1_busy_rise", 32'(busy), 32'd1);
        chk("m1_strobe", 32'(byte_strobe), 32'd1);
        chk("m1_byte0", 32'(byte_out), 32'h68);
        h = 8'h68;
        for (int c = 0; c < 80; c++) begin
            b = c / 8;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = h[b-1];
            chk("f0_bit_level", 32'(tx), 32'(e));
            if (c != 0) chk("f0_no_strobe", 32'(byte_strobe), 32'd0);
            tick;
        end
        chk("f1_start_bit", 32'(tx), 32'd0);
        chk("f1_strobe", 32'(byte_strobe), 32'd1);
        chk("f1_byte", 32'(byte_out), 32'h65);
        wait_done(1'b0);
        chk("m1_done_busy_low", 32'(busy), 32'd0);
        chk("m1_done_tx", 32'(tx), 32'd1);
        tick;
        chk("m1_done_width", 32'(done), 32'd0);
        chk("m1_done_latency", 32'(done_at - busy_rise), 32'd1040);
        chk("m1_busy_cycles", 32'(busy_hi - bh0), 32'd1040);
        chk("m1_strobes", 32'(strobes - s0), 32'd13);
        chk("m1_dones", 32'(dones - d0), 32'd1);
        for (int i = 0; i < 13; i++) chk("m1_byte_log", 32'(blog[(s0 + i) % 256]), 32'(msg[i]));

        // Message 2: decoded by UART model, extra start at byte 5 and on done
        s0 = strobes; d0 = dones;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) begin
                start = 1'b1;
                tick;
                start = 1'b0;
            end
            rx_frame(1'b0, d);
            chk("m2_rx_byte", 32'(d), 32'(msg[i]));
        end
        wait_done(1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("m2_done_start_ignored_busy", 32'(busy), 32'd0);
        chk("m2_done_start_ignored_tx", 32'(tx), 32'd1);
        chk("m2_strobes", 32'(strobes - s0), 32'd13);
        chk("m2_dones", 32'(dones - d0), 32'd1);

        // Message 3: start one cycle after done accepted, then reset at byte 4
        s0 = strobes; d0 = dones;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("m3_accept_busy", 32'(busy), 32'd1);
        chk("m3_accept_strobe", 32'(byte_strobe), 32'd1);
        chk("m3_accept_byte", 32'(byte_out), 32'h68);
        n = 0;
        while (strobes < s0 + 5 && n < 1000) begin
            tick;
            n++;
        end
        chk("m3_reach_byte4", 32'(n < 1000), 32'd1);
        chk("m3_byte4", 32'(byte_out), 32'h6F);
        repeat (20) tick;
        rst_n = 1'b0;
        #1;
        chk("m3_async_tx", 32'(tx), 32'd1);
        chk("m3_async_busy", 32'(busy), 32'd0);
        chk("m3_async_byte_out", 32'(byte_out), 32'h00);
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("m3_post_reset_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("m3_restart_byte", 32'(byte_out), 32'h68);
        for (int i = 0; i < 13; i++) begin
            rx_frame(1'b0, d);
            chk("m3_rx_byte", 32'(d), 32'(msg[i]));
        end
        wait_done(1'b0);
        tick;
        chk("m3_dones", 32'(dones - d0), 32'd1);

        // AUTO_START instance: one message after reset release, then idle
        tick;
        rst_a = 1'b1;
        for (int i = 0; i < 13; i++) begin
            rx_frame(1'b1, d);
            chk("auto_rx_byte", 32'(d), 32'(msg[i]));
        end
        wait_done(1'b1);
        tick;
        chk("auto_dones", 32'(dones_a), 32'd1);
        for (int i = 0; i < 200; i++) begin
            tick;
            chk("auto_idle_tx", 32'(tx_a), 32'd1);
            chk("auto_idle_busy", 32'(busy_a), 32'd0);
        end
        chk("auto_dones_final", 32'(dones_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
